// File: rtl/pmbist_pkg.sv
// rtl/pmbist_pkg.sv - shared types and constants for the PMBIST address generator
//
// Contents:
//   state_t        : sequencer state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   ADDR_W_DEFAULT : default address width
//   OPS_W          : width of the op-count / op-index fields
package pmbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int OPS_W          = 2;

endpackage

// File: rtl/pmbist_updown_cnt.sv
// rtl/pmbist_updown_cnt.sv - loadable up/down address counter with sweep-end flag
//
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (counter to 0)
//   load     in  load load_val (has priority over en)
//   load_val in  value loaded when load is high
//   en       in  step the counter one position
//   down     in  0 = count up, 1 = count down
//   cnt      out current count
//   at_end   out count is at the sweep end for the current direction
//                (MAX_ADDR when counting up, 0 when counting down)
module pmbist_updown_cnt #(
    parameter int ADDR_W   = 8,
    parameter int MAX_ADDR = 2**ADDR_W-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  logic              down,
    output logic [ADDR_W-1:0] cnt,
    output logic              at_end
);

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= down ? (cnt - ONE) : (cnt + ONE);
        end
    end

    assign at_end = down ? (cnt == '0) : (cnt == MAX_A);

endmodule

// File: rtl/pmbist_addr_gen.sv
// rtl/pmbist_addr_gen.sv - march-element address/op sequencer for PMBIST
//
// Sweeps addresses 0..MAX_ADDR (ascending) or MAX_ADDR..0 (descending),
// issuing 1..4 ops per address, paced by op_adv from the BIST controller.
//
// Ports:
//   clk          in  clock, rising edge
//   rst          in  synchronous active-high reset
//   start        in  begin one march element (honoured only when idle)
//   dir_down     in  sampled with start: 0 ascending, 1 descending
//   ops_per_addr in  sampled with start: ops per address minus 1
//   op_adv       in  current op issued; advance op/address
//   addr         out current memory address
//   op_idx       out index of current op within the address
//   busy         out element in progress
//   last_op      out current op is the final op of the element
//   done         out one-cycle pulse after the final op_adv
//
// Build option: PMBIST_ADDR_GRAY_EN drives addr with the Gray code of the
// internal binary counter (needs MAX_ADDR = 2**ADDR_W-1). End detection and
// last_op always use the binary counter.
module pmbist_addr_gen
    import pmbist_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int MAX_ADDR = 2**ADDR_W-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir_down,
    input  logic [OPS_W-1:0]  ops_per_addr,
    input  logic              op_adv,
    output logic [ADDR_W-1:0] addr,
    output logic [OPS_W-1:0]  op_idx,
    output logic              busy,
    output logic              last_op,
    output logic              done
);

    localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
    localparam logic [OPS_W-1:0]  OP_ONE = OPS_W'(1);

    state_t             state;
    state_t             state_nx;
    logic               dir_q;
    logic [OPS_W-1:0]   ops_q;
    logic [OPS_W-1:0]   op_idx_nx;
    logic               latch;
    logic               cnt_load;
    logic               cnt_en;
    logic [ADDR_W-1:0]  cnt;
    logic [ADDR_W-1:0]  load_val;
    logic               at_end;

    // The start address is taken from the live dir_down because it is
    // loaded in the same cycle that dir_down is latched.
    assign load_val = dir_down ? MAX_A : '0;

    pmbist_updown_cnt #(
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (load_val),
        .en       (cnt_en),
        .down     (dir_q),
        .cnt      (cnt),
        .at_end   (at_end)
    );

`ifdef PMBIST_ADDR_GRAY_EN
    assign addr = cnt ^ (cnt >> 1);
`else
    assign addr = cnt;
`endif

    assign last_op = (state == ST_RUN) && at_end && (op_idx == ops_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_idx <= '0;
            dir_q  <= 1'b0;
            ops_q  <= '0;
        end else begin
            state  <= state_nx;
            op_idx <= op_idx_nx;
            if (latch) begin
                dir_q <= dir_down;
                ops_q <= ops_per_addr;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        op_idx_nx = op_idx;
        latch     = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx  = ST_RUN;
                    latch     = 1'b1;
                    cnt_load  = 1'b1;
                    op_idx_nx = '0;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (op_adv) begin
                    if (op_idx != ops_q) begin
                        op_idx_nx = op_idx + OP_ONE;
                    end else if (!at_end) begin
                        op_idx_nx = '0;
                        cnt_en    = 1'b1;
                    end else begin
                        // Final op: hold addr/op_idx so the end position stays visible.
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pmbist_addr_gen.sv
// tb/tb_pmbist_addr_gen.sv - self-checking bench for pmbist_addr_gen
module tb_pmbist_addr_gen;

    localparam int AW   = 3;
    localparam int MAXA = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dir_down;
    logic [1:0]    ops_per_addr;
    logic          op_adv;
    logic [AW-1:0] addr;
    logic [1:0]    op_idx;
    logic          busy;
    logic          last_op;
    logic          done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pmbist_addr_gen #(
        .ADDR_W   (AW),
        .MAX_ADDR (MAXA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dir_down     (dir_down),
        .ops_per_addr (ops_per_addr),
        .op_adv       (op_adv),
        .addr         (addr),
        .op_idx       (op_idx),
        .busy         (busy),
        .last_op      (last_op),
        .done         (done)
    );

    // Address as seen on the port for a given position in the sweep.
    function automatic logic [AW-1:0] port_addr(input int b);
        logic [AW-1:0] v;
        v = AW'(b);
`ifdef PMBIST_ADDR_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    // Runs one march element. The expected sequence is the list of every
    // (address, op) pair in sweep order; each accepted op_adv consumes one.
    task automatic run_element(input bit dir, input int ops, input int duty_pct,
                               input bit mess, input bit start_in_done, input string tag);
        int            seq_a[$];
        int            seq_o[$];
        int            pos;
        int            cycles;
        int            len;
        logic [AW-1:0] ea;
        logic [AW-1:0] prev_a;
        logic          el;
        for (int i = 0; i <= MAXA; i++) begin
            for (int k = 0; k <= ops; k++) begin
                seq_a.push_back(dir ? (MAXA - i) : i);
                seq_o.push_back(k);
            end
        end
        len = seq_a.size();

        start        = 1'b1;
        dir_down     = dir;
        ops_per_addr = 2'(ops);
        op_adv       = 1'($urandom);
        @(negedge clk);
        start  = 1'b0;
        op_adv = 1'b0;

        pos    = 0;
        cycles = 0;
        prev_a = port_addr(seq_a[0]);
        while (pos < len && cycles < 4000) begin
            ea = port_addr(seq_a[pos]);
            el = (pos == len - 1);
            tests_run++;
            if (busy !== 1'b1 || done !== 1'b0 || addr !== ea ||
                op_idx !== 2'(seq_o[pos]) || last_op !== el) begin
                tests_failed++;
                $display("FAIL %s step %0d: got addr=%0d op=%0d busy=%b done=%b last=%b, want addr=%0d op=%0d busy=1 done=0 last=%b",
                         tag, pos, addr, op_idx, busy, done, last_op, ea, seq_o[pos], el);
            end
`ifdef PMBIST_ADDR_GRAY_EN
            if (pos > 0 && seq_o[pos] == 0) begin
                tests_run++;
                if ($countones(addr ^ prev_a) != 1) begin
                    tests_failed++;
                    $display("FAIL %s gray step %0d: got %0d->%0d, want one bit change",
                             tag, pos, prev_a, addr);
                end
            end
            prev_a = addr;
`endif
            op_adv = ($urandom_range(99) < duty_pct);
            if (mess) begin
                dir_down     = 1'($urandom);
                ops_per_addr = 2'($urandom);
                start        = 1'($urandom);
            end
            @(negedge clk);
            if (op_adv) pos++;
            cycles++;
        end
        if (pos < len) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s timeout: got %0d op_adv accepted, want %0d", tag, pos, len);
        end

        op_adv = 1'($urandom);
        start  = start_in_done;
        ea     = port_addr(seq_a[len-1]);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || last_op !== 1'b0 ||
            addr !== ea || op_idx !== 2'(ops)) begin
            tests_failed++;
            $display("FAIL %s done cycle: got done=%b busy=%b last=%b addr=%0d op=%0d, want done=1 busy=0 last=0 addr=%0d op=%0d",
                     tag, done, busy, last_op, addr, op_idx, ea, ops);
        end
        @(negedge clk);
        start  = 1'b0;
        op_adv = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after done: got done=%b busy=%b, want done=0 busy=0",
                     tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir_down = 1'b0; ops_per_addr = 2'd0; op_adv = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (addr !== 0 || op_idx !== 0 || busy !== 0 || done !== 0 || last_op !== 0) begin
            tests_failed++;
            $display("FAIL reset_init: got addr=%0d op=%0d busy=%b done=%b last=%b, want all 0",
                     addr, op_idx, busy, done, last_op);
        end
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        op_adv = 1'b1;
        repeat (5) @(negedge clk);
        op_adv = 1'b0;
        tests_run++;
        if (addr !== 3'd5 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre: got addr=%0d busy=%b, want addr=5 busy=1", addr, busy);
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (addr !== 0 || op_idx !== 0 || busy !== 0 || done !== 0) begin
                tests_failed++;
                $display("FAIL reset_mid cycle %0d: got addr=%0d op=%0d busy=%b done=%b, want all 0",
                         c, addr, op_idx, busy, done);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 0 || busy !== 0) begin
                tests_failed++;
                $display("FAIL reset_after cycle %0d: got done=%b busy=%b, want 0 0", c, done, busy);
            end
        end
    endtask

    task automatic test_ascending_1op();
        run_element(1'b0, 0, 100, 1'b0, 1'b0, "asc_1op");
    endtask

    task automatic test_descending_3op();
        run_element(1'b1, 2, 100, 1'b0, 1'b0, "desc_3op");
    endtask

    task automatic test_gaps_ignored();
        run_element(1'b0, 1, 50, 1'b1, 1'b0, "gaps_asc");
        run_element(1'b1, 3, 50, 1'b1, 1'b0, "gaps_desc");
    endtask

    task automatic test_back_to_back();
        run_element(1'b0, 0, 100, 1'b0, 1'b1, "b2b_first");
        run_element(1'b1, 1, 100, 1'b0, 1'b1, "b2b_second");
        run_element(1'b0, 3, 100, 1'b0, 1'b0, "b2b_third");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_element(1'($urandom), $urandom_range(3), $urandom_range(30, 100),
                        1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_ascending_1op();
        test_descending_3op();
        test_gaps_ignored();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
